// File: rtl/truxton2_cen_sched.sv
// Truxton 2 clock-enable scheduler: two fractional enable channels, /2 /4 /8 taps on
// channel A, shadowed ratio reconfiguration and a phase-aligned pause handshake.
module truxton2_cen_sched #(
   parameter int unsigned W      = 32'd8,
   parameter int unsigned DEF_NA = 32'd1,
   parameter int unsigned DEF_MA = 32'd7,
   parameter int unsigned DEF_NB = 32'd8,
   parameter int unsigned DEF_MB = 32'd189
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_cfg_we,
   input  logic         i_cfg_sel,
   input  logic [W-1:0] i_cfg_n,
   input  logic [W-1:0] i_cfg_m,
   output logic         o_cfg_ready,
   input  logic         i_pause_req,
   output logic         o_pause_ack,
   output logic [3:0]   o_cen_a,
   output logic [2:0]   o_cen_ab,
   output logic         o_cen_b
);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_FROZEN = 2'd2
   } state_t;

   localparam logic [W-1:0] ZERO = {W{1'b0}};

   // Returns {hit, next acc}; a zero operand disables the channel, n >= m hits every cycle.
   function automatic logic [W:0] frac_step(input logic [W-1:0] acc,
                                            input logic [W-1:0] n,
                                            input logic [W-1:0] m);
      logic [W:0] sum;
      logic [W:0] diff;
      sum  = {1'b0, acc} + {1'b0, n};
      diff = sum - {1'b0, m};
      if ((n == ZERO) || (m == ZERO)) begin
         frac_step = {1'b0, ZERO};
      end else if (n >= m) begin
         frac_step = {1'b1, ZERO};
      end else if (sum >= {1'b0, m}) begin
         frac_step = {1'b1, diff[W-1:0]};
      end else begin
         frac_step = {1'b0, sum[W-1:0]};
      end
   endfunction

   state_t       r_state;
   state_t       w_state_nxt;
   logic         r_req_q;
   logic         r_pause_ack;
   logic [W-1:0] r_na, r_ma, r_nb, r_mb;
   logic [W-1:0] r_sna, r_sma, r_snb, r_smb;
   logic         r_pend_a, r_pend_b;
   logic         r_ready;
   logic [W-1:0] r_acc_a, r_acc_b;
   logic [2:0]   r_cnt;
   logic [3:0]   r_cen_a;
   logic [2:0]   r_cen_ab;
   logic         r_cen_b;

   logic         w_frozen;
   logic [W:0]   w_step_a, w_step_b;
   logic         w_en_a, w_en_b;
   logic         w_hit_a, w_hit_b;
   logic [W-1:0] w_acc_a_upd, w_acc_b_upd;
   logic [W-1:0] w_acc_a_nxt, w_acc_b_nxt;
   logic         w_apply_a, w_apply_b;
   logic         w_accept;

   // Fractional step, freeze gating and shadow-apply decisions for both channels.
   always_comb begin
      w_frozen = (r_state == ST_FROZEN);
      w_step_a = frac_step(r_acc_a, r_na, r_ma);
      w_step_b = frac_step(r_acc_b, r_nb, r_mb);
      w_en_a   = (r_na != ZERO) && (r_ma != ZERO);
      w_en_b   = (r_nb != ZERO) && (r_mb != ZERO);
      w_hit_a  = w_step_a[W] & ~w_frozen;
      w_hit_b  = w_step_b[W] & ~w_frozen;
      if (w_frozen) begin
         w_acc_a_upd = r_acc_a;
         w_acc_b_upd = r_acc_b;
      end else begin
         w_acc_a_upd = w_step_a[W-1:0];
         w_acc_b_upd = w_step_b[W-1:0];
      end
      w_apply_a = r_pend_a & (w_hit_a | ~w_en_a | w_frozen);
      w_apply_b = r_pend_b & (w_hit_b | ~w_en_b | w_frozen);
      // A shrunken denominator must not leave acc at or above it.
      if (w_apply_a && (r_sma <= w_acc_a_upd)) begin
         w_acc_a_nxt = ZERO;
      end else begin
         w_acc_a_nxt = w_acc_a_upd;
      end
      if (w_apply_b && (r_smb <= w_acc_b_upd)) begin
         w_acc_b_nxt = ZERO;
      end else begin
         w_acc_b_nxt = w_acc_b_upd;
      end
      w_accept = r_ready & i_cfg_we;
   end

   // Pause FSM next state: drain to the /8 boundary before freezing.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN: begin
            if (i_pause_req && !r_req_q) w_state_nxt = ST_DRAIN;
            else                         w_state_nxt = ST_RUN;
         end
         ST_DRAIN: begin
            if (!i_pause_req)                                w_state_nxt = ST_RUN;
            else if (!w_en_a || (w_hit_a && r_cnt == 3'd7)) w_state_nxt = ST_FROZEN;
            else                                             w_state_nxt = ST_DRAIN;
         end
         ST_FROZEN: begin
            if (!i_pause_req) w_state_nxt = ST_RUN;
            else              w_state_nxt = ST_FROZEN;
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   // State, ratio, accumulator and registered enable outputs.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state     <= ST_RUN;
         r_req_q     <= 1'b0;
         r_pause_ack <= 1'b0;
         r_na        <= W'(DEF_NA);
         r_ma        <= W'(DEF_MA);
         r_nb        <= W'(DEF_NB);
         r_mb        <= W'(DEF_MB);
         r_sna       <= W'(DEF_NA);
         r_sma       <= W'(DEF_MA);
         r_snb       <= W'(DEF_NB);
         r_smb       <= W'(DEF_MB);
         r_pend_a    <= 1'b0;
         r_pend_b    <= 1'b0;
         r_ready     <= 1'b1;
         r_acc_a     <= ZERO;
         r_acc_b     <= ZERO;
         r_cnt       <= 3'd0;
         r_cen_a     <= 4'd0;
         r_cen_ab    <= 3'd0;
         r_cen_b     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_req_q     <= i_pause_req;
         r_pause_ack <= (w_state_nxt == ST_FROZEN);
         r_acc_a     <= w_acc_a_nxt;
         r_acc_b     <= w_acc_b_nxt;
         if (w_hit_a) r_cnt <= r_cnt + 3'd1;
         r_cen_a  <= {w_hit_a & (r_cnt[2:0] == 3'd0), w_hit_a & (r_cnt[1:0] == 2'd0),
                      w_hit_a & (r_cnt[0] == 1'b0), w_hit_a};
         r_cen_ab <= {w_hit_a & (r_cnt[2:0] == 3'd4), w_hit_a & (r_cnt[1:0] == 2'd2),
                      w_hit_a & (r_cnt[0] == 1'b1)};
         r_cen_b  <= w_hit_b;
         if (w_accept && !i_cfg_sel) begin
            r_sna    <= i_cfg_n;
            r_sma    <= i_cfg_m;
            r_pend_a <= 1'b1;
         end else if (w_apply_a) begin
            r_na     <= r_sna;
            r_ma     <= r_sma;
            r_pend_a <= 1'b0;
         end
         if (w_accept && i_cfg_sel) begin
            r_snb    <= i_cfg_n;
            r_smb    <= i_cfg_m;
            r_pend_b <= 1'b1;
         end else if (w_apply_b) begin
            r_nb     <= r_snb;
            r_mb     <= r_smb;
            r_pend_b <= 1'b0;
         end
         if (w_accept)                    r_ready <= 1'b0;
         else if (w_apply_a || w_apply_b) r_ready <= 1'b1;
      end
   end

   assign o_cfg_ready = r_ready;
   assign o_pause_ack = r_pause_ack;
   assign o_cen_a     = r_cen_a;
   assign o_cen_ab    = r_cen_ab;
   assign o_cen_b     = r_cen_b;

endmodule

// File: tb/tb_truxton2_cen_sched.sv
// Directed self-checking bench for truxton2_cen_sched: default cadence, reconfiguration,
// pause/resume, disabled and saturated channels, and reset out of a frozen state.
module tb_truxton2_cen_sched;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cfg_we = 1'b0;
   logic       cfg_sel = 1'b0;
   logic [7:0] cfg_n = 8'd0;
   logic [7:0] cfg_m = 8'd0;
   logic       cfg_ready;
   logic       pause_req = 1'b0;
   logic       pause_ack;
   logic [3:0] cen_a;
   logic [2:0] cen_ab;
   logic       cen_b;

   int n_asserts = 0;
   int n_fail    = 0;
   int cyc;

   truxton2_cen_sched dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_cfg_we    (cfg_we),
      .i_cfg_sel   (cfg_sel),
      .i_cfg_n     (cfg_n),
      .i_cfg_m     (cfg_m),
      .o_cfg_ready (cfg_ready),
      .i_pause_req (pause_req),
      .o_pause_ack (pause_ack),
      .o_cen_a     (cen_a),
      .o_cen_ab    (cen_ab),
      .o_cen_b     (cen_b)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      chk("rst_cen_a", cen_a, 4'd0);
      chk("rst_cen_ab", cen_ab, 3'd0);
      chk("rst_cen_b", cen_b, 1'b0);
      chk("rst_ack", pause_ack, 1'b0);
      chk("rst_ready", cfg_ready, 1'b1);
      rst = 1'b0;
   endtask

   // k counts running (non-frozen) cycles since reset; default ratios 1/7 and 8/189.
   task automatic run_dflt(input int k0, input int k1);
      logic [3:0] ea;
      logic [2:0] eab;
      logic       eb;
      for (int k = k0; k <= k1; k++) begin
         tick();
         ea  = {(k % 56) == 7, (k % 28) == 7, (k % 14) == 7, (k % 7) == 0};
         eab = {(k % 56) == 35, (k % 28) == 21, (k % 14) == 0};
         eb  = ((8 * k) / 189) != ((8 * (k - 1)) / 189);
         chk($sformatf("dflt_cen_a k=%0d", k), cen_a, ea);
         chk($sformatf("dflt_cen_ab k=%0d", k), cen_ab, eab);
         chk($sformatf("dflt_cen_b k=%0d", k), cen_b, eb);
      end
   endtask

   task automatic cfg_write(input logic sel, input logic [7:0] n, input logic [7:0] m);
      cfg_we  = 1'b1;
      cfg_sel = sel;
      cfg_n   = n;
      cfg_m   = m;
      tick();
      cfg_we  = 1'b0;
   endtask

   initial begin
      // Default cadence after reset.
      do_reset();
      run_dflt(1, 196);

      // Reconfigure A to 1/3 at k=197; a second write while busy is dropped.
      cfg_write(1'b0, 8'd1, 8'd3);
      chk("cfg13_ready_low", cfg_ready, 1'b0);
      cfg_write(1'b0, 8'd1, 8'd5);
      chk("cfg15_ignored_ready", cfg_ready, 1'b0);
      for (int k = 199; k <= 202; k++) begin
         tick();
         chk($sformatf("cfg13_wait_a0 k=%0d", k), cen_a[0], 1'b0);
         chk($sformatf("cfg13_wait_rdy k=%0d", k), cfg_ready, 1'b0);
      end
      tick();
      chk("cfg13_apply_a0", cen_a[0], 1'b1);
      chk("cfg13_apply_rdy", cfg_ready, 1'b1);
      for (int k = 204; k <= 221; k++) begin
         tick();
         chk($sformatf("cfg13_a0 k=%0d", k), cen_a[0], ((k - 203) % 3) == 0);
      end

      // Pause requested with cnt=2: drain to the cnt=7 pulse, then freeze.
      do_reset();
      run_dflt(1, 15);
      pause_req = 1'b1;
      run_dflt(16, 56);
      chk("pause_ack_entry", pause_ack, 1'b1);
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("frozen_cen_a", cen_a, 4'd0);
         chk("frozen_cen_ab", cen_ab, 3'd0);
         chk("frozen_cen_b", cen_b, 1'b0);
         chk("frozen_ack", pause_ack, 1'b1);
      end
      pause_req = 1'b0;
      tick();
      chk("release_ack", pause_ack, 1'b0);
      chk("release_cen_a", cen_a, 4'd0);
      run_dflt(57, 120);

      // Disable A (n=0), then pause: ack within two cycles.
      cfg_write(1'b0, 8'd0, 8'd7);
      cyc = 0;
      while (cfg_ready !== 1'b1 && cyc < 40) begin
         tick();
         cyc++;
      end
      chk("n0_apply_cycles", cyc, 5);
      pause_req = 1'b1;
      tick();
      chk("n0_drain_ack", pause_ack, 1'b0);
      chk("n0_drain_cen_a", cen_a, 4'd0);
      tick();
      chk("n0_frozen_ack", pause_ack, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("n0_frozen_cen_a", cen_a, 4'd0);
         chk("n0_frozen_cen_b", cen_b, 1'b0);
      end
      pause_req = 1'b0;
      tick();
      chk("n0_release_ack", pause_ack, 1'b0);

      // B = 9/5 saturates; then m=0 disables it.
      cfg_write(1'b1, 8'd9, 8'd5);
      chk("b95_ready_low", cfg_ready, 1'b0);
      cyc = 0;
      while (cfg_ready !== 1'b1 && cyc < 40) begin
         tick();
         cyc++;
      end
      chk("b95_ready", cfg_ready, 1'b1);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("b95_cen_b", cen_b, 1'b1);
         chk("b95_cen_a", cen_a, 4'd0);
      end
      cfg_write(1'b1, 8'd9, 8'd0);
      chk("bm0_load_cen_b", cen_b, 1'b1);
      chk("bm0_load_ready", cfg_ready, 1'b0);
      tick();
      chk("bm0_apply_cen_b", cen_b, 1'b1);
      chk("bm0_apply_ready", cfg_ready, 1'b1);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("bm0_cen_b", cen_b, 1'b0);
      end

      // Reset while frozen with a pending write restores defaults.
      pause_req = 1'b1;
      tick();
      tick();
      chk("rf_frozen_ack", pause_ack, 1'b1);
      cfg_write(1'b0, 8'd1, 8'd3);
      chk("rf_pending_ready", cfg_ready, 1'b0);
      rst       = 1'b1;
      pause_req = 1'b0;
      tick();
      chk("rf_ack", pause_ack, 1'b0);
      chk("rf_ready", cfg_ready, 1'b1);
      chk("rf_cen_a", cen_a, 4'd0);
      chk("rf_cen_ab", cen_ab, 3'd0);
      chk("rf_cen_b", cen_b, 1'b0);
      rst = 1'b0;
      run_dflt(1, 120);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/truxton2_cen_sched.md
Name: truxton2_cen_sched

Overview:
Runtime-programmable clock-enable scheduler for the Truxton 2 core.
- Generates, from one fast clock, the video/sound clock-enable tree:
  - Channel A: fractional base enable plus /2, /4 and /8 taps (GP9001 and YM2151 family).
  - Channel B: independent fractional enable (OKI).
- Provides a glitch-free ratio reconfiguration handshake and a phase-aligned pause/resume handshake used by OSD pause and savestate logic.

Parameters:
W, 8, width of the n and m ratio operands.
DEF_NA, 1, channel A numerator after reset.
DEF_MA, 7, channel A denominator after reset.
DEF_NB, 8, channel B numerator after reset.
DEF_MB, 189, channel B denominator after reset.

Ports:
CLK  in  1  96 MHz-class core clock; only clock.
RESET  in  1  synchronous, active-high reset.
CFG_WE  in  1  configuration write strobe, single cycle.
CFG_SEL  in  1  0 = channel A, 1 = channel B.
CFG_N  in  W  new numerator.
CFG_M  in  W  new denominator.
CFG_READY  out  1  high when a write will be accepted.
PAUSE_REQ  in  1  level request to freeze all enables.
PAUSE_ACK  out  1  high while frozen.
CEN_A  out  4  [0] base, [1] /2, [2] /4, [3] /8.
CEN_AB  out  3  [k-1] = antiphase of CEN_A[k], for k = 1..3.
CEN_B  out  1  channel B enable.

Behaviour:
- Reset (synchronous, active-high):
  - Accumulators = 0, tap counter cnt[2:0] = 0.
  - All CEN outputs = 0, PAUSE_ACK = 0, CFG_READY = 1.
  - Active and shadow ratios = DEF_*.
  - RESET mid-pause or mid-pending-write aborts it; defaults are restored.
- Fractional core, per channel, with sum = acc + n computed at W+1 bits:
  - If sum >= m: acc <= sum - m and hit = 1.
  - Otherwise: acc <= sum and hit = 0.
  - Enable outputs are registered: hit in cycle t gives the pulse in cycle t+1, one cycle wide.
  - n = 0 or m = 0: channel disabled; acc held at 0; no pulses.
  - n >= m: hit every cycle; acc held at 0.
- Taps, advanced only on channel A hit: cnt <= cnt + 1, wrapping 7 -> 0.
  - CEN_A[0] = hit.
  - CEN_A[k] = hit and cnt[k-1:0] == 0.
  - CEN_AB[k-1] = hit and cnt[k-1:0] == 2^(k-1).
- Configuration:
  - A write is accepted only when CFG_READY = 1 and CFG_WE = 1; it loads the shadow n/m of the selected channel and drops CFG_READY.
  - A write while CFG_READY = 0 is ignored.
  - Shadow is applied on the next hit of that channel, at the same clock edge as the acc update. That edge's update uses the old ratio; subsequent cycles use the new ratio. acc is not cleared.
  - CFG_READY returns high the cycle after the apply.
  - Disabled channel or PAUSE_ACK = 1: apply on the next cycle.
  - When applied, a new m that is <= acc forces acc to 0.
- Pause FSM, states RUN, DRAIN, FROZEN:
  - RUN -> DRAIN when PAUSE_REQ rises.
  - DRAIN -> FROZEN on the channel A hit that has cnt == 7 (wraps cnt to 0). Go straight to FROZEN if channel A is disabled.
  - FROZEN: both accumulators and cnt hold; all CEN outputs 0 from the cycle after entry; PAUSE_ACK = 1.
  - FROZEN -> RUN when PAUSE_REQ = 0. ACK falls that cycle; accumulation resumes the next cycle.
  - PAUSE_REQ dropped during DRAIN -> RUN immediately; no freeze occurs.
  - Channel B runs through DRAIN and freezes together with A.
- Simultaneous events:
  - CFG_WE in the same cycle as a hit loads the shadow only; the apply happens on the following hit.
  - RESET overrides every other input.

Test Plan:
- Defaults after reset: CEN_A[0] first pulse in the 7th cycle after RESET falls, then every 7 cycles; CEN_A[3] every 56 cycles; CEN_AB[2] pulses 28 cycles offset from CEN_A[3]; CEN_B gives exactly 8 pulses in any 189-cycle window, never two adjacent.
- Reconfigure A to n=1, m=3 mid-stream: CFG_READY low until the next A pulse; afterwards pulses occur every 3 cycles; a second CFG_WE while not ready leaves the ratio at 1/3.
- Pause with cnt=2: A keeps pulsing until the pulse with cnt=7, then all CEN outputs are 0 and PAUSE_ACK=1; after release, the first CEN_A[3] arrives 56 cycles later (full /8 period preserved).
- Program n=0 on A, then raise PAUSE_REQ: PAUSE_ACK rises within 2 cycles; CEN_A stays 0.
- n=9, m=5 on B: CEN_B high every cycle; then m=0: CEN_B stays 0.
- RESET asserted while FROZEN with a pending write: next cycle PAUSE_ACK=0, CFG_READY=1, and the default cadence resumes exactly as in the first test.
